// File: rtl/silent_lpf_pkg.sv
// Shared types and constants for the silent-mode low-pass filter.
package silent_lpf_pkg;

  localparam int unsigned SHIFT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    LINEAR   = 1'b0,
    CIRCULAR = 1'b1
  } mode_e;

endpackage

// File: rtl/silent_lpf_step.sv
// One first-order smoothing step: y_new = y + step(x - y).
// LINEAR treats samples as unsigned magnitudes; CIRCULAR takes the shortest
// path around the 2^WIDTH ring (half-turn tie goes negative).
// Optional macro SILENT_LPF_STEP_LIMIT_EN clamps |step| to STEP_MAX.
module silent_lpf_step
  import silent_lpf_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter mode_e       MODE     = LINEAR
`ifdef SILENT_LPF_STEP_LIMIT_EN
  ,
  parameter int unsigned STEP_MAX = 8
`endif
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               bypass,
  output logic [WIDTH-1:0]   y_new
);

  localparam int unsigned DW = WIDTH + 1;

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] step_raw;
  logic signed [DW-1:0] step_fix;
  logic signed [DW-1:0] step;

  // Signed distance from current output to target
  if (MODE == CIRCULAR) begin : g_circ
    logic [WIDTH-1:0] wrap_d;
    assign wrap_d = x - y;
    assign diff   = {wrap_d[WIDTH-1], wrap_d};
  end else begin : g_lin
    assign diff = $signed({1'b0, x}) - $signed({1'b0, y});
  end

  // Shifted step with a minimum magnitude of one so the output always converges
  always_comb begin
    step_raw = bypass ? diff : (diff >>> shift);
    step_fix = step_raw;
    if (!bypass && (step_raw == '0) && (diff != '0)) begin
      step_fix = diff[DW-1] ? {DW{1'b1}} : DW'(1);
    end
  end

`ifdef SILENT_LPF_STEP_LIMIT_EN
  localparam logic signed [DW-1:0] SMAX = DW'(STEP_MAX);

  // Slew-rate clamp
  always_comb begin
    if (step_fix > SMAX) begin
      step = SMAX;
    end else if (step_fix < -SMAX) begin
      step = -SMAX;
    end else begin
      step = step_fix;
    end
  end
`else
  assign step = step_fix;
`endif

  // Apply step; low bits give the ring wrap for CIRCULAR and stay in range for LINEAR
  always_comb begin
    y_new = WIDTH'({1'b0, y} + step);
  end

endmodule

// File: rtl/silent_lpf_v3.sv
// Time-multiplexed duty/phase smoother: one shared datapath sweeps all
// channels once every PERIOD cycles from a snapshot of the inputs.
// Optional macro SILENT_LPF_STEP_LIMIT_EN limits the per-update step to STEP_MAX.
module silent_lpf_v3
  import silent_lpf_pkg::*;
#(
  parameter int unsigned TRANS_NUM = 249,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PERIOD    = 256,
  parameter int unsigned STEP_MAX  = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ENABLE,
  input  logic [SHIFT_W-1:0]         SHIFT,
  input  logic [WIDTH*TRANS_NUM-1:0] DUTY,
  input  logic [WIDTH*TRANS_NUM-1:0] PHASE,
  output logic [WIDTH*TRANS_NUM-1:0] DUTYS,
  output logic [WIDTH*TRANS_NUM-1:0] PHASES,
  output logic                       BUSY,
  output logic                       SWEEP_DONE
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned IW = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;

  if ((PERIOD <= TRANS_NUM + 1) || (STEP_MAX < 1)) begin : g_param_check
    $error("silent_lpf_v3: PERIOD must exceed TRANS_NUM+1 and STEP_MAX must be >= 1");
  end

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               snap_en_q, snap_en_d;
  logic [SHIFT_W-1:0] snap_shift_q, snap_shift_d;
  logic [WIDTH-1:0]   snap_duty_q  [TRANS_NUM];
  logic [WIDTH-1:0]   snap_duty_d  [TRANS_NUM];
  logic [WIDTH-1:0]   snap_phase_q [TRANS_NUM];
  logic [WIDTH-1:0]   snap_phase_d [TRANS_NUM];
  logic [WIDTH-1:0]   dutys_q      [TRANS_NUM];
  logic [WIDTH-1:0]   dutys_d      [TRANS_NUM];
  logic [WIDTH-1:0]   phases_q     [TRANS_NUM];
  logic [WIDTH-1:0]   phases_d     [TRANS_NUM];

  logic               cnt_last;
  logic               idx_last;
  logic [WIDTH-1:0]   duty_new;
  logic [WIDTH-1:0]   phase_new;

  assign cnt_last = (cnt_q == CW'(PERIOD - 1));
  assign idx_last = (idx_q == IW'(TRANS_NUM - 1));

  // Free-running period counter
  always_comb begin
    cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
  end

  silent_lpf_step #(
    .WIDTH    (WIDTH),
    .MODE     (LINEAR)
`ifdef SILENT_LPF_STEP_LIMIT_EN
    ,
    .STEP_MAX (STEP_MAX)
`endif
  ) u_duty_step (
    .x      (snap_duty_q[idx_q]),
    .y      (dutys_q[idx_q]),
    .shift  (snap_shift_q),
    .bypass (~snap_en_q),
    .y_new  (duty_new)
  );

  silent_lpf_step #(
    .WIDTH    (WIDTH),
    .MODE     (CIRCULAR)
`ifdef SILENT_LPF_STEP_LIMIT_EN
    ,
    .STEP_MAX (STEP_MAX)
`endif
  ) u_phase_step (
    .x      (snap_phase_q[idx_q]),
    .y      (phases_q[idx_q]),
    .shift  (snap_shift_q),
    .bypass (~snap_en_q),
    .y_new  (phase_new)
  );

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      snap_en_q    <= 1'b0;
      snap_shift_q <= '0;
      for (int i = 0; i < TRANS_NUM; i++) begin
        snap_duty_q[i]  <= '0;
        snap_phase_q[i] <= '0;
        dutys_q[i]      <= '0;
        phases_q[i]     <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      snap_en_q    <= snap_en_d;
      snap_shift_q <= snap_shift_d;
      snap_duty_q  <= snap_duty_d;
      snap_phase_q <= snap_phase_d;
      dutys_q      <= dutys_d;
      phases_q     <= phases_d;
    end
  end

  // Next state: start a sweep at counter wrap, stop after the last channel
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_last) state_d = RUN;
      RUN:     if (idx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot capture, per-channel write-back and status flags
  always_comb begin
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    snap_en_d    = snap_en_q;
    snap_shift_d = snap_shift_q;
    snap_duty_d  = snap_duty_q;
    snap_phase_d = snap_phase_q;
    dutys_d      = dutys_q;
    phases_d     = phases_q;
    case (state_q)
      IDLE: begin
        if (cnt_last) begin
          snap_en_d    = ENABLE;
          snap_shift_d = SHIFT;
          for (int i = 0; i < TRANS_NUM; i++) begin
            snap_duty_d[i]  = DUTY[i*WIDTH +: WIDTH];
            snap_phase_d[i] = PHASE[i*WIDTH +: WIDTH];
          end
          idx_d  = '0;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        dutys_d[idx_q]  = duty_new;
        phases_d[idx_q] = phase_new;
        idx_d           = idx_q + IW'(1);
        if (idx_last) begin
          idx_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Pack registered channel outputs onto the flat buses
  for (genvar g = 0; g < TRANS_NUM; g++) begin : g_out
    assign DUTYS[g*WIDTH +: WIDTH]  = dutys_q[g];
    assign PHASES[g*WIDTH +: WIDTH] = phases_q[g];
  end

  assign BUSY       = busy_q;
  assign SWEEP_DONE = done_q;

endmodule

// File: tb/tb_silent_lpf_v3.sv
// Self-checking bench for silent_lpf_v3 with an arithmetic reference model.
module tb_silent_lpf_v3;

  localparam int TN  = 249;
  localparam int W   = 8;
  localparam int PER = 256;
  localparam int M   = 1 << W;
`ifdef SILENT_LPF_STEP_LIMIT_EN
  localparam int SM  = 4;
`else
  localparam int SM  = 8;
`endif

  logic            clk;
  logic            rst;
  logic            en;
  logic [3:0]      sh;
  logic [W*TN-1:0] duty_bus;
  logic [W*TN-1:0] phase_bus;
  logic [W*TN-1:0] dutys;
  logic [W*TN-1:0] phases;
  logic            busy;
  logic            done;

  logic [W-1:0] duty_in  [TN];
  logic [W-1:0] phase_in [TN];
  int           exp_d    [TN];
  int           exp_p    [TN];

  int tests;
  int fails;

  silent_lpf_v3 #(
    .TRANS_NUM (TN),
    .WIDTH     (W),
    .PERIOD    (PER),
    .STEP_MAX  (SM)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .ENABLE     (en),
    .SHIFT      (sh),
    .DUTY       (duty_bus),
    .PHASE      (phase_bus),
    .DUTYS      (dutys),
    .PHASES     (phases),
    .BUSY       (busy),
    .SWEEP_DONE (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    duty_bus  = '0;
    phase_bus = '0;
    for (int i = 0; i < TN; i++) begin
      duty_bus[i*W +: W]  = duty_in[i];
      phase_bus[i*W +: W] = phase_in[i];
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int out_d(int i);
    return int'(dutys[i*W +: W]);
  endfunction

  function automatic int out_p(int i);
    return int'(phases[i*W +: W]);
  endfunction

  // Reference: smoothing rule expressed with integer floor division
  function automatic int mdl(int x, int y, int s, bit filt, bit circ);
    int diff;
    int st;
    int p;
    if (circ) begin
      diff = (x - y + M) % M;
      if (diff >= M / 2) diff = diff - M;
    end else begin
      diff = x - y;
    end
    if (!filt) begin
      st = diff;
    end else begin
      p = 1 << s;
      if (diff >= 0) st = diff / p;
      else st = -((-diff + p - 1) / p);
      if (st == 0 && diff != 0) st = (diff > 0) ? 1 : -1;
    end
`ifdef SILENT_LPF_STEP_LIMIT_EN
    if (st > SM) st = SM;
    if (st < -SM) st = -SM;
`endif
    return ((y + st) % M + M) % M;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_all(input int d, input int p);
    for (int i = 0; i < TN; i++) begin
      duty_in[i]  = W'(d);
      phase_in[i] = W'(p);
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < TN; i++) begin
      duty_in[i]  = W'($urandom);
      phase_in[i] = W'($urandom);
    end
  endtask

  task automatic check_all_model();
    int bad_d;
    int bad_p;
    bad_d = 0;
    bad_p = 0;
    for (int i = 0; i < TN; i++) begin
      if (out_d(i) != exp_d[i]) bad_d++;
      if (out_p(i) != exp_p[i]) bad_p++;
    end
    check("duty_channels_bad", bad_d, 0);
    check("phase_channels_bad", bad_p, 0);
  endtask

  // Run one sweep from the next snapshot; optionally check per-channel timing,
  // change inputs mid-sweep, or assert reset at RUN cycle abort_at.
  task automatic sweep(input bit timing, input bit scramble, input int abort_at);
    int nd [TN];
    int np [TN];
    int n;
    int k;
    int nz;
    for (int i = 0; i < TN; i++) begin
      nd[i] = mdl(int'(duty_in[i]), exp_d[i], int'(sh), en, 1'b0);
      np[i] = mdl(int'(phase_in[i]), exp_p[i], int'(sh), en, 1'b1);
    end
    n = 0;
    while (!busy && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      check("busy_rise_timeout", 0, 1);
      return;
    end
    k = 0;
    while (busy && k < TN + 2) begin
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        nz = 0;
        for (int i = 0; i < TN; i++) if (out_d(i) != 0 || out_p(i) != 0) nz++;
        check("abort_outputs_nonzero", nz, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < TN; i++) begin
          exp_d[i] = 0;
          exp_p[i] = 0;
        end
        return;
      end
      if (timing) begin
        check("pending_duty", out_d(k), exp_d[k]);
        check("pending_phase", out_p(k), exp_p[k]);
        if (k > 0) begin
          check("written_duty", out_d(k - 1), nd[k - 1]);
          check("written_phase", out_p(k - 1), np[k - 1]);
        end
      end
      if (scramble && k == TN / 2) set_rand();
      @(negedge clk);
      k++;
    end
    check("busy_cycles", k, TN);
    check("done_pulse", done, 1);
    for (int i = 0; i < TN; i++) begin
      exp_d[i] = nd[i];
      exp_p[i] = np[i];
    end
    check_all_model();
    @(negedge clk);
    check("done_clear", done, 0);
  endtask

  int wrap_seq [12] = '{251, 252, 253, 254, 255, 0, 1, 2, 3, 4, 5, 5};
  int conv_seq [4]  = '{1, 2, 3, 3};
  int n_wait;
  int nz0;

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    en    = 1'b1;
    sh    = 4'd4;
    set_all(0, 0);
    for (int i = 0; i < TN; i++) begin
      exp_d[i] = 0;
      exp_p[i] = 0;
    end
    repeat (3) @(negedge clk);
    nz0 = 0;
    for (int i = 0; i < TN; i++) if (out_d(i) != 0 || out_p(i) != 0) nz0++;
    check("reset_outputs_nonzero", nz0, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    // Duty ramp toward 255 with SHIFT=4
    set_all(255, 0);
    en = 1'b1;
    sh = 4'd4;
    sweep(1'b1, 1'b0, -1);
`ifndef SILENT_LPF_STEP_LIMIT_EN
    check("ramp1_ch0", out_d(0), 15);
    check("ramp1_last", out_d(TN - 1), 15);
`endif
    sweep(1'b0, 1'b0, -1);
`ifndef SILENT_LPF_STEP_LIMIT_EN
    check("ramp2_ch0", out_d(0), 30);
`endif

    // Phase wrap: preload 250 through bypass, then creep up through 255 -> 0 -> 5
    set_all(0, 250);
    for (int i = 0; i < TN; i++) duty_in[i] = W'($urandom);
    en = 1'b0;
    sweep(1'b1, 1'b1, -1);
`ifndef SILENT_LPF_STEP_LIMIT_EN
    check("preload_phase", out_p(0), 250);
`endif
    set_all(0, 5);
    en = 1'b1;
    sh = 4'd4;
    for (int s = 0; s < 12; s++) begin
      sweep(1'b0, 1'b0, -1);
`ifndef SILENT_LPF_STEP_LIMIT_EN
      check("wrap_seq_ch0", out_p(0), wrap_seq[s]);
`endif
    end

    // Half-turn tie resolves negative
    set_all(0, 0);
    en = 1'b0;
    sweep(1'b0, 1'b0, -1);
    set_all(0, 128);
    en = 1'b1;
    sh = 4'd4;
    sweep(1'b0, 1'b0, -1);
`ifndef SILENT_LPF_STEP_LIMIT_EN
    check("half_turn_ch0", out_p(0), 248);
`endif

    // Convergence with minimum step of one
    set_all(0, 0);
    en = 1'b0;
    sweep(1'b0, 1'b0, -1);
    set_all(3, 0);
    en = 1'b1;
    sh = 4'd4;
    for (int s = 0; s < 4; s++) begin
      sweep(1'b0, 1'b0, -1);
      check("converge_ch0", out_d(0), conv_seq[s]);
    end

    // Randomized modes, shifts and data with mid-sweep input changes
    for (int r = 0; r < 5; r++) begin
      set_rand();
      en = 1'($urandom);
      sh = 4'($urandom);
      sweep(1'b1, 1'b1, -1);
    end

    // Reset mid-sweep, then restart at counter wrap
    set_rand();
    en = 1'b1;
    sh = 4'd2;
    sweep(1'b0, 1'b0, 100);
    set_all(255, 255);
    en = 1'b1;
    sh = 4'd0;
    n_wait = 0;
    do begin
      @(negedge clk);
      n_wait++;
    end while (!busy && n_wait < 2 * PER);
    check("restart_delay", n_wait, PER);
    sweep(1'b0, 1'b0, -1);
`ifdef SILENT_LPF_STEP_LIMIT_EN
    check("limit1_ch0", out_d(0), 4);
`else
    check("shift0_ch0", out_d(0), 255);
`endif
    sweep(1'b0, 1'b0, -1);
`ifdef SILENT_LPF_STEP_LIMIT_EN
    check("limit2_ch0", out_d(0), 8);
`else
    check("shift0_hold_ch0", out_d(0), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
